// File: rtl/shift_reg_tx_if.sv
// Handshake and serial-output bundle for the parallel-to-serial transmitter.
// The slave modport is the transmitter; the master modport is whoever feeds it words.
interface shift_reg_tx_if #(
  parameter int unsigned N = 8
) ();
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         abort;
  logic         ser_data;
  logic         ser_enable;
  logic         busy;
  logic         done;

  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, ser_data, ser_enable, busy, done
  );

  modport master (
    output in_valid, in_data, abort,
    input  in_ready, ser_data, ser_enable, busy, done
  );
endinterface

// File: rtl/shift_reg_tx.sv
// Parallel-to-serial transmitter: shifts an N-bit word out MSB-first, one bit per DIV cycles,
// with a strobe on the last cycle of each bit period.
module shift_reg_tx #(
  parameter int unsigned N   = 8,
  parameter int unsigned DIV = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  shift_reg_tx_if.slave bus
);

  localparam int unsigned BW = $clog2(N + 1);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LastBit = BW'(N - 1);
  localparam logic [DW-1:0] LastDiv = DW'(DIV - 1);
  // With DIV == 1 every cycle of a bit period is also its last, so the strobe starts high.
  localparam logic StrobeFirst = (DIV == 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e         state_q;
  logic [N-1:0]   shreg_q;
  logic [BW-1:0]  bit_cnt_q;
  logic [DW-1:0]  div_cnt_q;
  logic           ser_enable_q;
  logic           busy_q;
  logic           done_q;

  logic [DW-1:0]  div_inc;
  logic [N-1:0]   shreg_nxt;

  assign div_inc   = div_cnt_q + DW'(1);
  assign shreg_nxt = shreg_q << 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      ser_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ser_enable_q <= 1'b0;
          if (bus.in_valid) begin
            state_q      <= StShift;
            shreg_q      <= bus.in_data;
            ser_enable_q <= StrobeFirst;
            busy_q       <= 1'b1;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
          end
        end
        StShift: begin
          if (bus.abort) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            ser_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
          end else if (div_cnt_q == LastDiv) begin
            div_cnt_q <= '0;
            if (bit_cnt_q == LastBit) begin
              state_q      <= StIdle;
              shreg_q      <= '0;
              ser_enable_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              bit_cnt_q    <= '0;
            end else begin
              shreg_q      <= shreg_nxt;
              bit_cnt_q    <= bit_cnt_q + BW'(1);
              ser_enable_q <= StrobeFirst;
            end
          end else begin
            div_cnt_q    <= div_inc;
            ser_enable_q <= (div_inc == LastDiv);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The shift register is cleared whenever the block returns to idle, so its MSB doubles as
  // the registered serial output and reads 0 outside a transfer.
  assign bus.ser_data   = shreg_q[N-1];
  assign bus.ser_enable = ser_enable_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.in_ready   = (state_q == StIdle);

endmodule

// File: tb/tb_shift_reg_tx.sv
// Bench for shift_reg_tx: table of transfers on DIV=1 and DIV=3 instances with a bit
// scoreboard and a serial loader model, plus back-to-back, reset and N=1 sequences.
module tb_shift_reg_tx;
  localparam int unsigned N = 8;

  int n_checks = 0;
  int n_pass   = 0;
  int strobes  = 0;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         sel       = 1'b0;  // 0 selects the DIV=1 instance, 1 the DIV=3 instance
  logic         drv_valid = 1'b0;
  logic         drv_abort = 1'b0;
  logic [N-1:0] drv_data  = '0;
  logic         c_valid   = 1'b0;
  logic         c_data    = 1'b0;

  shift_reg_tx_if #(.N(N)) if_a ();
  shift_reg_tx_if #(.N(N)) if_b ();
  shift_reg_tx_if #(.N(1)) if_c ();

  assign if_a.in_valid = drv_valid & ~sel;
  assign if_a.abort    = drv_abort & ~sel;
  assign if_a.in_data  = drv_data;
  assign if_b.in_valid = drv_valid & sel;
  assign if_b.abort    = drv_abort & sel;
  assign if_b.in_data  = drv_data;
  assign if_c.in_valid = c_valid;
  assign if_c.abort    = 1'b0;
  assign if_c.in_data  = c_data;

  shift_reg_tx #(.N(N), .DIV(1)) u_a (.clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  shift_reg_tx #(.N(N), .DIV(3)) u_b (.clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  shift_reg_tx #(.N(1), .DIV(1)) u_c (.clk(clk), .reset_n(reset_n), .bus(if_c.slave));

  logic o_en, o_data, o_busy, o_done, o_ready;
  always_comb begin
    o_en    = sel ? if_b.ser_enable : if_a.ser_enable;
    o_data  = sel ? if_b.ser_data   : if_a.ser_data;
    o_busy  = sel ? if_b.busy       : if_a.busy;
    o_done  = sel ? if_b.done       : if_a.done;
    o_ready = sel ? if_b.in_ready   : if_a.in_ready;
  end

  // Serial-in loader as seen by the configuration chain.
  logic       ld_clr = 1'b0;
  logic [7:0] ld_q   = '0;
  always @(posedge clk) begin
    if (ld_clr)    ld_q <= '0;
    else if (o_en) ld_q <= {ld_q[6:0], o_data};
  end

  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cycle_check(input string tag, input logic e_en, input logic e_data,
                             input logic e_busy, input logic e_done, input logic e_ready);
    check({tag, ".ser_enable"}, o_en, e_en);
    check({tag, ".ser_data"}, o_data, e_data);
    check({tag, ".busy"}, o_busy, e_busy);
    check({tag, ".done"}, o_done, e_done);
    check({tag, ".in_ready"}, o_ready, e_ready);
    if (o_en) begin
      strobes++;
      check({tag, ".sb_nonempty"}, exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check({tag, ".sb_bit"}, o_data, exp_q.pop_front());
    end
  endtask

  // One transfer; cycle c is c cycles after the handshake edge.
  task automatic xfer(input string tag, input logic s, input logic [N-1:0] data, input int div,
                      input int abort_at, input bit poke);
    int total;
    logic live, e_data;
    total = N * div;
    sel = s;
    @(negedge clk);
    check({tag, ".pre_ready"}, o_ready, 1);
    drv_data  = data;
    drv_valid = 1'b1;
    ld_clr    = 1'b1;
    for (int i = N - 1; i >= 0; i--) exp_q.push_back(data[i]);
    strobes = 0;
    for (int c = 1; c <= total + 2; c++) begin
      @(negedge clk);
      ld_clr = 1'b0;
      live   = (c <= total) && !(abort_at != 0 && c > abort_at);
      e_data = 1'b0;
      if (live) e_data = data[N - 1 - (c - 1) / div];
      cycle_check(tag, live && (c % div == 0), e_data, live,
                  abort_at == 0 && c == total + 1, !live);
      drv_valid = poke && c == 2;
      drv_data  = poke ? ~data : data;
      drv_abort = abort_at != 0 && c == abort_at;
    end
    drv_valid = 1'b0;
    drv_abort = 1'b0;
  endtask

  typedef struct {
    logic       s;
    logic [7:0] data;
    int         div;
    int         abort_at;
    bit         poke;
    int         exp_strobes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1, 0, 1'b0, 8};
    vecs[1] = '{1'b1, 8'h81, 3, 0, 1'b0, 8};
    vecs[2] = '{1'b0, 8'h3C, 1, 4, 1'b0, 4};
    vecs[3] = '{1'b1, 8'hC3, 3, 6, 1'b0, 2};
    vecs[4] = '{1'b0, 8'h5A, 1, 0, 1'b1, 8};
    vecs[5] = '{1'b1, 8'h96, 3, 0, 1'b1, 8};

    // Reset state on all instances.
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      sel = j[0];
      #1;
      cycle_check($sformatf("reset%0d", j), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("reset_c.ser_enable", if_c.ser_enable, 0);
    check("reset_c.in_ready", if_c.in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      xfer($sformatf("vec%0d", v), vecs[v].s, vecs[v].data, vecs[v].div, vecs[v].abort_at,
           vecs[v].poke);
      check($sformatf("vec%0d.strobes", v), strobes, vecs[v].exp_strobes);
      check($sformatf("vec%0d.sb_left", v), exp_q.size(), 8 - vecs[v].exp_strobes);
      if (vecs[v].abort_at == 0) check($sformatf("vec%0d.loader", v), ld_q, vecs[v].data);
      exp_q.delete();
    end

    // Back-to-back 0xFF then 0x00 with in_valid held high.
    sel = 1'b0;
    @(negedge clk);
    drv_data  = 8'hFF;
    drv_valid = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    strobes = 0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      drv_data = 8'h00;
      cycle_check($sformatf("b2b.c%0d", c), (c <= 8) || (c >= 10 && c <= 17), c <= 8,
                  (c <= 8) || (c >= 10 && c <= 17), c == 9 || c == 18, !((c <= 8) ||
                  (c >= 10 && c <= 17)));
      if (c == 9) for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
      if (c == 10) drv_valid = 1'b0;
    end
    check("b2b.strobes", strobes, 16);
    check("b2b.sb_left", exp_q.size(), 0);
    exp_q.delete();

    // Async reset in the middle of a DIV=3 transfer.
    sel = 1'b1;
    @(negedge clk);
    drv_data  = 8'hFF;
    drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid.busy_before", o_busy, 1);
    reset_n = 1'b0;
    #1;
    cycle_check("rst_mid.during", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    strobes = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cycle_check($sformatf("rst_mid.after%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("rst_mid.strobes", strobes, 0);

    // N=1, DIV=1: single strobe, then done.
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      c_data  = j[0] ? 1'b0 : 1'b1;
      c_valid = 1'b1;
      @(negedge clk);
      c_valid = 1'b0;
      check($sformatf("n1_%0d.en", j), if_c.ser_enable, 1);
      check($sformatf("n1_%0d.data", j), if_c.ser_data, j[0] ? 1'b0 : 1'b1);
      check($sformatf("n1_%0d.ready", j), if_c.in_ready, 0);
      @(negedge clk);
      check($sformatf("n1_%0d.done", j), if_c.done, 1);
      check($sformatf("n1_%0d.en_off", j), if_c.ser_enable, 0);
      check($sformatf("n1_%0d.ready_done", j), if_c.in_ready, 1);
      @(negedge clk);
      check($sformatf("n1_%0d.done_clr", j), if_c.done, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_tx.md
# shift_reg_tx

Parallel-to-serial transmitter for the serial configuration chain. It accepts an N-bit word over a valid/ready handshake and shifts it out MSB-first as a data bit plus a one-cycle sample strobe. The output format matches the chain's serial-in loader: the loader shifts left and ORs in each strobed bit, so the first bit sent lands in its MSB. The block sits in the configuration master, driving the loader's enable and data inputs.

## Interface
- N, 8: word width in bits; N >= 1.
- DIV, 1: clock cycles per serial bit; DIV >= 1.
- clk  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a word to send.
- in_data  input  N  word to transmit, MSB sent first.
- in_ready  output  1  block can accept a word. Equal to (state == IDLE), decoded directly from the state register.
- abort  input  1  synchronous cancel of a transfer in progress.
- ser_data  output  1  serial bit, registered.
- ser_enable  output  1  strobe, registered: the receiver samples ser_data in any cycle where this is high.
- busy  output  1  transfer in progress, registered.
- done  output  1  one-cycle pulse when the last bit's strobe has completed, registered.

## Operation
- Reset (async assert, sync to clk on release):
  - state = IDLE, internal shift register = 0, bit_cnt = 0, div_cnt = 0.
  - Outputs: ser_data = 0, ser_enable = 0, busy = 0, done = 0, in_ready = 1.
- Counter widths:
  - bit_cnt is clog2(N+1) bits.
  - div_cnt is clog2(DIV) bits, minimum 1.
  - Both counters wrap-free: each is cleared explicitly and never exceeds its terminal value.
- States:
  - IDLE: in_ready = 1.
    - If in_valid = 1 (a handshake): load in_data into the shift register, set ser_data = in_data[N-1], busy = 1, bit_cnt = 0, div_cnt = 0, and go to SHIFT.
    - Otherwise: ser_data = 0 and ser_enable = 0.
  - SHIFT: ser_data holds the current MSB for DIV cycles.
    - On the last cycle of each bit period (div_cnt == DIV-1), ser_enable = 1; otherwise 0.
    - At the end of each bit period: shift left by one, increment bit_cnt, clear div_cnt, and present the next MSB on ser_data.
    - After bit N-1's strobe: go to IDLE with done = 1, busy = 0, ser_data = 0.
- done is 1 only in the first IDLE cycle after a completed transfer; it is cleared on the following edge.
- in_data is sampled only at the handshake. Changing it during SHIFT has no effect.
- in_valid is ignored outside IDLE.
- abort:
  - In SHIFT, abort = 1 at a rising edge moves the block to IDLE on that edge: ser_enable = 0, ser_data = 0, busy = 0, and done stays 0.
  - A strobe that was already high in the abort cycle has already happened; no further strobes follow.
  - In IDLE, abort has no effect, and a handshake in the same cycle is still accepted. abort is only acted on in SHIFT.
- Back-to-back words: a handshake in the done cycle is legal. The next word's first bit appears in the following cycle with no gap.

## Timing
- Let the handshake occur at the edge ending cycle k.
  - For i = 0..N-1: bit in_data[N-1-i] is on ser_data in cycles k+1+i*DIV through k+(i+1)*DIV.
  - ser_enable = 1 only in cycle k+(i+1)*DIV.
  - busy = 1 in cycles k+1 through k+N*DIV.
  - Cycle k+N*DIV+1: done = 1, in_ready = 1, busy = 0.
- Latency from handshake to first strobe is DIV cycles. The whole transfer is N*DIV cycles plus 1 done cycle.
- N = 1 with DIV = 1: a single strobe in cycle k+1, then done in k+2.
- Async reset mid-transfer drops all outputs to their reset values immediately. No partial strobe may be generated after reset_n deasserts.

## Test plan
- N=8, DIV=1, send 0xA5:
  - ser_enable is high for cycles k+1..k+8, with ser_data = 1,0,1,0,0,1,0,1.
  - done in k+9.
  - A connected loader with N=8 ends at 0xA5 and locks.
- N=8, DIV=3, send 0x81:
  - 8 strobes, one every 3 cycles, on k+3, k+6, …, k+24.
  - ser_data stable across each 3-cycle period.
  - done in k+25.
- Back-to-back 0xFF then 0x00 with in_valid held high:
  - Second word's first bit appears in the cycle after the first word's done.
  - No idle gap; exactly 16 strobes total.
  - in_ready is low throughout both shifts except the done cycle.
- abort asserted in cycle k+4 of a DIV=1 transfer:
  - Strobes occur only in k+1..k+4.
  - From k+5: busy = 0, ser_enable = 0, in_ready = 1, and done never pulses.
- reset_n pulsed low mid-transfer:
  - All outputs 0 and in_ready = 1 during reset.
  - After release: no strobes until a new handshake.
- in_data changed during SHIFT, and in_valid pulsed while busy: transmitted bits match the word captured at the handshake, and no extra transfer starts.
